game_menu_ctrl: RTL

Top-level menu/mode controller that drives the game datapath's control inputs (`vgaMUX`, `choice`, `speedcontrol`, `gamein_rst`) from the datapath's debounced button feedback and `exit` level. It sits between the debounced-button and exit feedback of the datapath and its mode-select inputs. It implements the menu cursor, game launch with a guaranteed game-reset window, play mode, exit handling and an idle timeout back to the background screen.

---
 rtl/game_menu_pkg.sv | 46 ++++
 rtl/game_menu_if.sv | 28 ++
 rtl/game_menu_ctrl_btn_edge.sv | 23 ++
 rtl/game_menu_ctrl.sv | 121 ++++++++++++
 4 files changed

// File: rtl/game_menu_pkg.sv
// Shared types, mux codes and small helpers for the game menu controller.
package game_menu_pkg;

    typedef enum logic [1:0] {
        MENU   = 2'd0,
        LAUNCH = 2'd1,
        PLAY   = 2'd2,
        RETURN = 2'd3
    } state_t;

    localparam logic [1:0] MUX_BG    = 2'd0;
    localparam logic [1:0] MUX_GAME1 = 2'd1;
    localparam logic [1:0] MUX_GAME2 = 2'd2;
    localparam int         NUM_GAMES = 2;

    typedef struct packed {
        logic start;
        logic up;
        logic down;
        logic left;
        logic right;
    } btn_t;

    function automatic logic [1:0] cur_prev(input logic [1:0] c);
        return (c == 2'd0) ? 2'(NUM_GAMES - 1) : c - 2'd1;
    endfunction

    function automatic logic [1:0] cur_next(input logic [1:0] c);
        return (c == 2'(NUM_GAMES - 1)) ? 2'd0 : c + 2'd1;
    endfunction

    function automatic logic [1:0] game_mux(input logic [1:0] c);
        return (c == 2'd0) ? MUX_GAME1 : MUX_GAME2;
    endfunction

    function automatic logic [3:0] spd_dec(input logic [3:0] s,
                                           input logic [3:0] lo);
        return (s > lo) ? s - 4'd1 : lo;
    endfunction

    function automatic logic [3:0] spd_inc(input logic [3:0] s,
                                           input logic [3:0] hi);
        return (s < hi) ? s + 4'd1 : hi;
    endfunction

endpackage

// File: rtl/game_menu_if.sv
// Button/exit feedback from the datapath and its mode-select controls.
interface game_menu_if;

    logic       button_up;
    logic       button_down;
    logic       button_left;
    logic       button_right;
    logic       start;
    logic       exit;
    logic [1:0] vgaMUX;
    logic [1:0] choice;
    logic [3:0] speedcontrol;
    logic       gamein_rst;
    logic       in_game;

    modport master (
        input  button_up, button_down, button_left, button_right,
        input  start, exit,
        output vgaMUX, choice, speedcontrol, gamein_rst, in_game
    );

    modport slave (
        output button_up, button_down, button_left, button_right,
        output start, exit,
        input  vgaMUX, choice, speedcontrol, gamein_rst, in_game
    );

endinterface

// File: rtl/game_menu_ctrl_btn_edge.sv
// Rising-edge detector: one history flop and an AND gate.
module btn_edge #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic level,
    output logic rise
);

    logic level_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            level_q <= RST_VAL;
        end else begin
            level_q <= level;
        end
    end

    assign rise = level & ~level_q;

endmodule

// File: rtl/game_menu_ctrl.sv
// Menu/mode controller: cursor, speed, launch reset window, play, exit
// and idle timeout back to the background screen.
module game_menu_ctrl
    import game_menu_pkg::*;
#(
    parameter int         RST_CYCLES    = 16,
    parameter logic [31:0] IDLE_CYCLES  = 32'd3_000_000_000,
    parameter logic [3:0] SPEED_DEFAULT = 4'd5,
    parameter logic [3:0] SPEED_MIN     = 4'd1,
    parameter logic [3:0] SPEED_MAX     = 4'd15
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    game_menu_if.master bus
);

    localparam int LW = $clog2(RST_CYCLES + 1);
    localparam logic [LW-1:0] LAUNCH_LAST = LW'(RST_CYCLES);

    logic [4:0]    lvl;
    logic [4:0]    rise;
    btn_t          ev;
    state_t        state;
    logic [1:0]    mux_q;
    logic [1:0]    choice_q;
    logic [3:0]    speed_q;
    logic          grst_q;
    logic          play_q;
    logic [LW-1:0] lcnt;
    logic [31:0]   idle;
    logic          idle_hit;

    assign lvl = {bus.start, bus.button_up, bus.button_down,
                  bus.button_left, bus.button_right};

    // History flops reset high so a button held through reset is not an edge.
    for (genvar i = 0; i < 5; i++) begin : g_edge
        btn_edge #(
            .RST_VAL(1'b1)
        ) u_edge (
            .clk  (sys_clk),
            .rst  (sys_rst),
            .level(lvl[i]),
            .rise (rise[i])
        );
    end

    assign ev = btn_t'(rise);

    assign idle_hit = (IDLE_CYCLES != 32'd0) &&
                      (idle == IDLE_CYCLES - 32'd1);

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state    <= MENU;
            mux_q    <= MUX_BG;
            choice_q <= 2'd0;
            speed_q  <= SPEED_DEFAULT;
            grst_q   <= 1'b1;
            play_q   <= 1'b0;
            lcnt     <= '0;
            idle     <= '0;
        end else begin
            unique case (state)
                MENU: begin
                    if (ev.start) begin
                        state <= LAUNCH;
                        mux_q <= game_mux(choice_q);
                        lcnt  <= '0;
                    end else if (ev.up) begin
                        choice_q <= cur_prev(choice_q);
                    end else if (ev.down) begin
                        choice_q <= cur_next(choice_q);
                    end else if (ev.left) begin
                        speed_q <= spd_dec(speed_q, SPEED_MIN);
                    end else if (ev.right) begin
                        speed_q <= spd_inc(speed_q, SPEED_MAX);
                    end
                end
                LAUNCH: begin
                    if (bus.exit) begin
                        state <= RETURN;
                        mux_q <= MUX_BG;
                    end else if (lcnt == LAUNCH_LAST) begin
                        state  <= PLAY;
                        grst_q <= 1'b0;
                        play_q <= 1'b1;
                        idle   <= '0;
                    end else begin
                        lcnt <= lcnt + 1'b1;
                    end
                end
                PLAY: begin
                    if (bus.exit || (idle_hit && rise == 5'd0)) begin
                        state  <= RETURN;
                        mux_q  <= MUX_BG;
                        grst_q <= 1'b1;
                        play_q <= 1'b0;
                    end else if (rise != 5'd0) begin
                        idle <= '0;
                    end else if (idle != '1) begin
                        idle <= idle + 32'd1;
                    end
                end
                RETURN: begin
                    if (!bus.exit) begin
                        state <= MENU;
                    end
                end
                default: state <= MENU;
            endcase
        end
    end

    assign bus.vgaMUX       = mux_q;
    assign bus.choice       = choice_q;
    assign bus.speedcontrol = speed_q;
    assign bus.gamein_rst   = grst_q;
    assign bus.in_game      = play_q;

endmodule
